// File: rtl/ibex_bus_arb_pkg.sv
// Shared types and constants for the Ibex fetch/data bus arbiter.
package ibex_bus_arb_pkg;

  typedef enum logic {
    ArbSrcInstr = 1'b0,
    ArbSrcData  = 1'b1
  } arb_src_e;

  // Fetches are always full-word reads.
  localparam logic [3:0]  FetchBe        = 4'hF;
  localparam logic [31:0] FetchWdata     = 32'h0;
  localparam logic [6:0]  FetchWdataIntg = 7'h0;

endpackage

// File: rtl/ibex_bus_arb_fifo.sv
// In-order record of the source of each granted, not-yet-answered transaction.
module ibex_bus_arb_fifo
  import ibex_bus_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  arb_src_e        data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output arb_src_e        head_o,
  output logic [CntW-1:0] count_o
);

  arb_src_e        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && pop_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ibex_bus_arb.sv
// Shares one req/gnt/rvalid host port between Ibex fetch and data interfaces,
// routing in-order responses back by the recorded source of each grant.
module ibex_bus_arb
  import ibex_bus_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_addr_o,
  output logic [31:0] host_wdata_o,
  output logic [6:0]  host_wdata_intg_o,
  output logic        host_instr_type_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic [6:0]  host_rdata_intg_i,
  input  logic        host_err_i,
  output logic        unexp_rsp_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [3:0]  StarveMax = 4'(StarveLimit);

  arb_src_e        sel;
  logic            sel_req;
  logic            lock_q, lock_d;
  arb_src_e        lock_src_q, lock_src_d;
  logic [3:0]      starve_q, starve_d;
  logic            unexp_q, unexp_d;
  logic            push, pop, full, empty;
  arb_src_e        head;
  logic [CntW-1:0] count;

  always_comb begin
    sel = ArbSrcInstr;
    if (lock_q) begin
      sel = lock_src_q;
    end else if (data_req_i && !(instr_req_i && starve_q == StarveMax)) begin
      sel = ArbSrcData;
    end
    sel_req    = (sel == ArbSrcData) ? data_req_i : instr_req_i;
    host_req_o = sel_req && !full && !rst_i;

    // Fields are zeroed when nothing is requested so idle outputs read as 0.
    host_we_o         = 1'b0;
    host_be_o         = 4'h0;
    host_addr_o       = 32'h0;
    host_wdata_o      = 32'h0;
    host_wdata_intg_o = 7'h0;
    host_instr_type_o = 1'b0;
    if (host_req_o) begin
      if (sel == ArbSrcData) begin
        host_we_o         = data_we_i;
        host_be_o         = data_be_i;
        host_addr_o       = data_addr_i;
        host_wdata_o      = data_wdata_i;
        host_wdata_intg_o = data_wdata_intg_i;
      end else begin
        host_be_o         = FetchBe;
        host_addr_o       = instr_addr_i;
        host_wdata_o      = FetchWdata;
        host_wdata_intg_o = FetchWdataIntg;
        host_instr_type_o = 1'b1;
      end
    end

    instr_gnt_o = host_req_o && host_gnt_i && (sel == ArbSrcInstr);
    data_gnt_o  = host_req_o && host_gnt_i && (sel == ArbSrcData);

    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (host_req_o && !host_gnt_i) begin
      lock_d     = 1'b1;
      lock_src_d = sel;
    end else if (host_gnt_i) begin
      lock_d = 1'b0;
    end

    starve_d = starve_q;
    if (!instr_req_i || instr_gnt_o) begin
      starve_d = 4'h0;
    end else if (data_gnt_o && starve_q != StarveMax) begin
      starve_d = starve_q + 4'h1;
    end

    unexp_d = unexp_q || (host_rvalid_i && empty);
  end

  assign push = host_req_o && host_gnt_i;
  assign pop  = host_rvalid_i && !empty;

  ibex_bus_arb_fifo #(
    .Depth(MaxOutstanding)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (sel),
    .pop_i  (pop),
    .full_o (full),
    .empty_o(empty),
    .head_o (head),
    .count_o(count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= ArbSrcInstr;
      starve_q   <= 4'h0;
      unexp_q    <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      starve_q   <= starve_d;
      unexp_q    <= unexp_d;
    end
  end

  assign instr_rvalid_o     = pop && !rst_i && (head == ArbSrcInstr);
  assign data_rvalid_o      = pop && !rst_i && (head == ArbSrcData);
  assign instr_rdata_o      = host_rdata_i;
  assign instr_rdata_intg_o = host_rdata_intg_i;
  assign instr_err_o        = host_err_i;
  assign data_rdata_o       = host_rdata_i;
  assign data_rdata_intg_o  = host_rdata_intg_i;
  assign data_err_o         = host_err_i;
  assign unexp_rsp_o        = unexp_q;

endmodule

// File: tb/tb_ibex_bus_arb.sv
// Self-checking bench for ibex_bus_arb: vector table plus response scoreboard.
module tb_ibex_bus_arb;
  import ibex_bus_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, igr, irv, ierr, dreq, dwe, dgr, drv, derr;
  logic [31:0] iaddr, irdata, daddr, dwdata, drdata;
  logic [6:0]  irintg, dwintg, drintg;
  logic [3:0]  dbe;
  logic        hreq, hgnt, hwe, htype, hrv, herr, unexp;
  logic [3:0]  hbe;
  logic [31:0] haddr, hwdata, hrdata;
  logic [6:0]  hwintg, hrintg;

  ibex_bus_arb #(
    .MaxOutstanding(2),
    .StarveLimit   (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .instr_req_i       (ireq),
    .instr_addr_i      (iaddr),
    .instr_gnt_o       (igr),
    .instr_rvalid_o    (irv),
    .instr_rdata_o     (irdata),
    .instr_rdata_intg_o(irintg),
    .instr_err_o       (ierr),
    .data_req_i        (dreq),
    .data_we_i         (dwe),
    .data_be_i         (dbe),
    .data_addr_i       (daddr),
    .data_wdata_i      (dwdata),
    .data_wdata_intg_i (dwintg),
    .data_gnt_o        (dgr),
    .data_rvalid_o     (drv),
    .data_rdata_o      (drdata),
    .data_rdata_intg_o (drintg),
    .data_err_o        (derr),
    .host_req_o        (hreq),
    .host_gnt_i        (hgnt),
    .host_we_o         (hwe),
    .host_be_o         (hbe),
    .host_addr_o       (haddr),
    .host_wdata_o      (hwdata),
    .host_wdata_intg_o (hwintg),
    .host_instr_type_o (htype),
    .host_rvalid_i     (hrv),
    .host_rdata_i      (hrdata),
    .host_rdata_intg_i (hrintg),
    .host_err_i        (herr),
    .unexp_rsp_o       (unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        ireq, dreq, dwe;
    logic [3:0]  dbe;
    logic [31:0] iaddr, daddr, dwdata;
    logic [6:0]  dintg;
    logic        hgnt;
    logic        ereq, ewe;
    logic [3:0]  ebe;
    logic [31:0] eaddr, ewdata;
    logic [6:0]  eintg;
    logic        etype, eig, edg;
  } vec_t;
  vec_t vecs[6];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_gnt(input string name, input logic ei, input logic ed);
    chk({name, " instr_gnt"}, 32'(igr), 32'(ei));
    chk({name, " data_gnt"}, 32'(dgr), 32'(ed));
  endtask

  task automatic idle_inputs();
    ireq = 0; iaddr = 0; dreq = 0; dwe = 0; dbe = 0; daddr = 0; dwdata = 0; dwintg = 0;
    hgnt = 0; hrv = 0; hrdata = 0; hrintg = 0; herr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    sb_q.delete();
  endtask

  task automatic push_exp(input logic src, input logic [31:0] rdata);
    sb_t e;
    e.src   = src;
    e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  // Responder echoes the scoreboard head's tag so routing and data can be checked.
  task automatic drive_rsp();
    hrv    = 1;
    hrdata = (sb_q.size() > 0) ? sb_q[0].rdata : 32'hBAD0_0BAD;
    hrintg = hrdata[6:0];
    herr   = hrdata[0];
  endtask

  task automatic rsp_check(input string name);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk({name, " unexp instr_rvalid"}, 32'(irv), 32'd0);
      chk({name, " unexp data_rvalid"}, 32'(drv), 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, " instr_rvalid"}, 32'(irv), 32'(e.src == ArbSrcInstr));
      chk({name, " data_rvalid"}, 32'(drv), 32'(e.src == ArbSrcData));
      if (e.src == ArbSrcInstr) begin
        chk({name, " instr_rdata"}, irdata, e.rdata);
        chk({name, " instr_intg"}, 32'(irintg), 32'(e.rdata[6:0]));
        chk({name, " instr_err"}, 32'(ierr), 32'(e.rdata[0]));
      end else begin
        chk({name, " data_rdata"}, drdata, e.rdata);
        chk({name, " data_intg"}, 32'(drintg), 32'(e.rdata[6:0]));
        chk({name, " data_err"}, 32'(derr), 32'(e.rdata[0]));
      end
    end
  endtask

  task automatic drain(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      idle_inputs();
      drive_rsp();
      settle();
      rsp_check(name);
      tick();
    end
    idle_inputs();
  endtask

  task automatic chk_idle(input string name);
    chk({name, " host_req"}, 32'(hreq), 32'd0);
    chk({name, " host_be"}, 32'(hbe), 32'd0);
    chk({name, " host_addr"}, haddr, 32'd0);
    chk({name, " host_type"}, 32'(htype), 32'd0);
    chk({name, " gnts"}, 32'({igr, dgr}), 32'd0);
    chk({name, " rvalids"}, 32'({irv, drv}), 32'd0);
    chk({name, " unexp"}, 32'(unexp), 32'd0);
  endtask

  initial begin
    rst = 1;
    idle_inputs();

    // ireq dreq dwe dbe iaddr daddr dwdata dintg hgnt | req we be addr wdata intg type ig dg
    vecs[0] = '{1, 0, 1, 4'h3, 32'h100, 32'h2000, 32'h11, 7'h2A, 1,
                1, 0, 4'hF, 32'h100, 32'h0, 7'h0, 1, 1, 0};
    vecs[1] = '{0, 1, 1, 4'h3, 32'h100, 32'h2000, 32'h1234_5678, 7'h5A, 1,
                1, 1, 4'h3, 32'h2000, 32'h1234_5678, 7'h5A, 0, 0, 1};
    vecs[2] = '{1, 1, 0, 4'hF, 32'h104, 32'h3000, 32'h0, 7'h0, 1,
                1, 0, 4'hF, 32'h3000, 32'h0, 7'h0, 0, 0, 1};
    vecs[3] = '{1, 1, 1, 4'hC, 32'h104, 32'h3004, 32'hCAFE_0000, 7'h11, 0,
                1, 1, 4'hC, 32'h3004, 32'hCAFE_0000, 7'h11, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 4'h5, 32'h108, 32'h3008, 32'h55, 7'h33, 1,
                0, 0, 4'h0, 32'h0, 32'h0, 7'h0, 0, 0, 0};
    vecs[5] = '{1, 0, 0, 4'h0, 32'h200, 32'h0, 32'h0, 7'h0, 0,
                1, 0, 4'hF, 32'h200, 32'h0, 7'h0, 1, 0, 0};

    tick();
    settle();
    chk_idle("in_reset");
    do_reset();
    settle();
    chk_idle("after_reset");

    foreach (vecs[i]) begin
      do_reset();
      ireq = vecs[i].ireq; dreq = vecs[i].dreq; dwe = vecs[i].dwe; dbe = vecs[i].dbe;
      iaddr = vecs[i].iaddr; daddr = vecs[i].daddr; dwdata = vecs[i].dwdata;
      dwintg = vecs[i].dintg; hgnt = vecs[i].hgnt;
      settle();
      chk($sformatf("vec%0d host_req", i), 32'(hreq), 32'(vecs[i].ereq));
      chk($sformatf("vec%0d host_we", i), 32'(hwe), 32'(vecs[i].ewe));
      chk($sformatf("vec%0d host_be", i), 32'(hbe), 32'(vecs[i].ebe));
      chk($sformatf("vec%0d host_addr", i), haddr, vecs[i].eaddr);
      chk($sformatf("vec%0d host_wdata", i), hwdata, vecs[i].ewdata);
      chk($sformatf("vec%0d host_wintg", i), 32'(hwintg), 32'(vecs[i].eintg));
      chk($sformatf("vec%0d host_type", i), 32'(htype), 32'(vecs[i].etype));
      chk_gnt($sformatf("vec%0d", i), vecs[i].eig, vecs[i].edg);
      if (vecs[i].eig || vecs[i].edg) push_exp(vecs[i].edg, 32'hA500_0000 + 32'(i * 3));
      tick();
      if (sb_q.size() > 0) drain($sformatf("vec%0d rsp", i), 1);
    end

    // Lone fetch answered two cycles after its grant.
    do_reset();
    ireq = 1; iaddr = 32'h0000_0100; hgnt = 1;
    settle();
    chk_gnt("fetch", 1, 0);
    chk("fetch type", 32'(htype), 32'd1);
    chk("fetch be", 32'(hbe), 32'hF);
    push_exp(ArbSrcInstr, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    tick();
    drain("fetch rsp", 1);

    // Starvation: both requesting, host always granting and answering.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      ireq = 1; iaddr = 32'h1000; dreq = 1; daddr = 32'h2000; hgnt = 1;
      hrv = 0;
      if (c > 0) drive_rsp();
      settle();
      chk_gnt($sformatf("starve c%0d", c), (c == 4 || c == 9), !(c == 4 || c == 9));
      if (c > 0) rsp_check($sformatf("starve rsp c%0d", c));
      push_exp((c == 4 || c == 9) ? ArbSrcInstr : ArbSrcData, 32'h5000_0000 + 32'(c));
      tick();
    end
    drain("starve drain", 1);

    // Data held off for three cycles stays selected once instr joins.
    do_reset();
    dreq = 1; daddr = 32'h4000;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("dlock c%0d addr", c), haddr, 32'h4000);
      chk_gnt($sformatf("dlock c%0d", c), 0, 0);
      tick();
    end
    ireq = 1; iaddr = 32'h104; hgnt = 1;
    settle();
    chk("dlock c3 addr", haddr, 32'h4000);
    chk_gnt("dlock c3", 0, 1);
    push_exp(ArbSrcData, 32'h0000_4444);
    tick();
    dreq = 0;
    settle();
    chk_gnt("dlock c4", 1, 0);
    chk("dlock c4 addr", haddr, 32'h104);
    push_exp(ArbSrcInstr, 32'h0000_1111);
    tick();
    drain("dlock rsp", 2);

    // Instr locked while waiting keeps the port even when data arrives.
    do_reset();
    ireq = 1; iaddr = 32'h300;
    settle();
    chk_gnt("ilock c0", 0, 0);
    tick();
    dreq = 1; daddr = 32'h5000;
    settle();
    chk("ilock c1 addr", haddr, 32'h300);
    chk("ilock c1 type", 32'(htype), 32'd1);
    tick();
    hgnt = 1;
    settle();
    chk_gnt("ilock c2", 1, 0);
    push_exp(ArbSrcInstr, 32'h0000_3333);
    tick();
    ireq = 0;
    settle();
    chk_gnt("ilock c3", 0, 1);
    chk("ilock c3 addr", haddr, 32'h5000);
    push_exp(ArbSrcData, 32'h0000_5555);
    tick();
    drain("ilock rsp", 2);

    // Outstanding limit, no pop-then-push bypass, in-order return.
    do_reset();
    ireq = 1; iaddr = 32'h600; hgnt = 1;
    settle();
    chk_gnt("full c0", 1, 0);
    push_exp(ArbSrcInstr, 32'h0000_6666);
    tick();
    ireq = 0; dreq = 1; daddr = 32'h700;
    settle();
    chk_gnt("full c1", 0, 1);
    push_exp(ArbSrcData, 32'h0000_7777);
    tick();
    settle();
    chk("full c2 host_req", 32'(hreq), 32'd0);
    chk_gnt("full c2", 0, 0);
    tick();
    drive_rsp();
    settle();
    chk("full c3 host_req", 32'(hreq), 32'd0);
    chk_gnt("full c3", 0, 0);
    rsp_check("full c3 rsp");
    tick();
    drive_rsp();
    settle();
    chk("full c4 host_req", 32'(hreq), 32'd1);
    chk_gnt("full c4", 0, 1);
    rsp_check("full c4 rsp");
    push_exp(ArbSrcData, 32'h0000_8888);
    tick();
    drain("full drain", 1);

    // Response with nothing outstanding is dropped and flagged until reset.
    do_reset();
    settle();
    chk("unexp before", 32'(unexp), 32'd0);
    drive_rsp();
    settle();
    rsp_check("unexp pulse");
    tick();
    idle_inputs();
    settle();
    chk("unexp set", 32'(unexp), 32'd1);
    tick();
    settle();
    chk("unexp sticky", 32'(unexp), 32'd1);
    do_reset();
    settle();
    chk("unexp cleared", 32'(unexp), 32'd0);

    // Reset with two in flight discards them; late answer becomes unexpected.
    do_reset();
    ireq = 1; iaddr = 32'h800; hgnt = 1;
    tick();
    ireq = 0; dreq = 1; daddr = 32'h900;
    tick();
    rst = 1;
    idle_inputs();
    hrv = 1; hrdata = 32'h1234;
    settle();
    chk("rst rvalids", 32'({irv, drv}), 32'd0);
    tick();
    rst = 0;
    sb_q.delete();
    idle_inputs();
    settle();
    chk_idle("post_rst");
    drive_rsp();
    settle();
    rsp_check("post_rst late");
    tick();
    idle_inputs();
    settle();
    chk("post_rst unexp", 32'(unexp), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_bus_arb.md
Name: ibex_bus_arb

Overview:
- Shares one core-side req/gnt/rvalid host port between the Ibex instruction-fetch and data interfaces, so a single tlul_adapter_host can carry both onto one TL-UL port.
- Sits between ibex_top and the adapter.
- Arbitrates requests, holds the selection stable while a request is pending, and records the source of every granted transaction in order.
- Uses that record to route in-order responses back to the correct requester.

Parameters:
- MaxOutstanding, 2: maximum granted-but-unanswered transactions, range 1..4. Default matches the adapter's MAX_REQS.
- StarveLimit, 4: number of consecutive data wins while instr is waiting before instr is forced to win once. Range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_rdata_intg_o  out  7  fetch read-data integrity
- instr_err_o  out  1  fetch bus error
- data_req_i  in  1  data request
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  data write data
- data_wdata_intg_i  in  7  data write-data integrity
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_rdata_intg_o  out  7  data read-data integrity
- data_err_o  out  1  data bus error
- host_req_o  out  1  request to adapter
- host_gnt_i  in  1  adapter grant
- host_we_o  out  1  write enable
- host_be_o  out  4  byte enables
- host_addr_o  out  32  address
- host_wdata_o  out  32  write data
- host_wdata_intg_o  out  7  write-data integrity
- host_instr_type_o  out  1  1 = fetch transaction
- host_rvalid_i  in  1  response valid
- host_rdata_i  in  32  read data
- host_rdata_intg_i  in  7  read-data integrity
- host_err_i  in  1  response error
- unexp_rsp_o  out  1  sticky: response arrived with nothing outstanding

Behaviour:
- Reset (rst_i high at a clock edge):
  - Clears outstanding FIFO, count, lock, starve counter and unexp_rsp_o.
  - All outputs are 0 during and after reset until a request is made.
  - Transactions in flight are discarded. Their late responses are treated as unexpected.
- Selection, when not locked and count < MaxOutstanding:
  - Data wins over instr by default.
  - Instr wins instead when starve_cnt == StarveLimit.
  - Only one requester: it wins.
- Blocking: when count == MaxOutstanding, host_req_o = 0 and both gnt = 0. There is no same-cycle pop-then-push bypass.
- Host-side fields:
  - host_* carry the selected source.
  - A fetch drives we = 0, be = 4'hF, wdata = 0, wdata_intg = 7'h0 and host_instr_type_o = 1.
- Grant: selected_gnt_o = host_gnt_i; the other source's gnt is 0. Same-cycle, combinational.
- Lock:
  - If host_req_o && !host_gnt_i, register the selected source and lock.
  - While locked, the same source stays selected regardless of priority.
  - Unlock on host_gnt_i.
  - Requesters must hold req until gnt; a de-asserted req while locked is a protocol violation and is not checked.
- Starve counter:
  - Increments, saturating at StarveLimit, on a data grant while instr_req_i is high.
  - Clears on an instr grant, or on any cycle where instr_req_i is low.
- Outstanding FIFO:
  - Depth MaxOutstanding, 1-bit entries (source).
  - Push on host_req_o && host_gnt_i; pop on host_rvalid_i.
  - Push and pop in the same cycle: count is unchanged, pointers both advance and wrap modulo depth.
- Response routing:
  - On host_rvalid_i with count > 0, the head source gets rvalid = 1 plus rdata, rdata_intg and err in the same cycle (zero latency). The other source gets rvalid = 0.
  - rdata, rdata_intg and err pass through unconditionally; only rvalid is gated.
  - With count == 0, host_rvalid_i is dropped, no rvalid is generated, and unexp_rsp_o sets until reset.
- Latency: arbitration and routing are combinational. State updates on the next clock edge.

Decomposition:
- Shared package ibex_bus_arb_pkg holds:
  - typedef arb_src_e {ArbSrcInstr = 1'b0, ArbSrcData = 1'b1};
  - the fetch constants (be 4'hF, zero wdata/intg).
- One sub-module, ibex_bus_arb_fifo: a pointer/count FIFO of arb_src_e with push, pop, full, empty, head and count.

Test Plan:
- Only instr_req_i, addr 0x0000_0100, host_gnt_i = 1, rvalid 2 cycles later with rdata 0xDEAD_BEEF -> instr_gnt_o the same cycle, instr_rvalid_o = 1 with 0xDEAD_BEEF, host_instr_type_o = 1, host_be_o = 4'hF.
- Both requesting continuously, host always granting, StarveLimit = 4 -> grant sequence D, D, D, D, I, D, D, D, D, I.
- Data selected, host_gnt_i held 0 for 3 cycles, then instr also rises -> host_addr_o stays the data address, data_gnt_o pulses on the 4th cycle, then instr is served.
- MaxOutstanding = 2: grant I then D with no responses -> third request sees host_req_o = 0. Responses then return in order: first to instr_rvalid_o, second to data_rvalid_o.
- host_rvalid_i pulsed with nothing outstanding -> no rvalid to either source, unexp_rsp_o = 1 until rst_i.
- rst_i asserted with 2 outstanding -> count 0 and outputs 0 next cycle; a subsequent rvalid sets unexp_rsp_o.
